run_controller: RTL

- Host-side sequencer directly upstream of the CPU top level.
- Preloads data memory from a byte stream, pulses the CPU start request, and waits for done with a cycle counter and timeout.
- Then streams a window of data memory back out to the host.
- Owns the data-memory write/address port while not RUN; the CPU owns memory during RUN, and top-level muxing uses busy_run.

---
 rtl/run_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// rtl/run_controller.sv - host sequencer: preload data memory, launch CPU with timeout, stream memory window back.
// Optional define RUN_CTRL_CHECKSUM_EN enables the mod-256 sum of unloaded bytes on checksum.
module run_controller #(
  parameter int AW      = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] load_base,
  input  logic [AW:0]   load_len,
  input  logic [AW-1:0] unload_base,
  input  logic [AW:0]   unload_len,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdat,
  input  logic [7:0]    mem_rdat,
  output logic          cpu_req,
  input  logic          cpu_done,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy_run,
  output logic          busy,
  output logic [CW-1:0] cycles,
  output logic          timed_out,
  output logic          finished,
  output logic [7:0]    checksum
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_RUN, S_UNLOAD, S_DONE} state_t;

  localparam logic [CW-1:0] CYC_MAX = '1;
  localparam logic [CW-1:0] TMO_M1  = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);

  state_t        state, state_nx;
  logic [AW-1:0] load_ptr, unload_ptr;
  logic [AW:0]   load_rem, unload_rem;
  logic          run_done, run_tmo;

  // A done level is ignored in the first RUN cycle (cycles still 0) so a stale halt from the last job cannot end this one.
  assign run_done = (state == S_RUN) && cpu_done && (cycles != '0);
  assign run_tmo  = (state == S_RUN) && (cycles == TMO_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = (load_len != '0) ? S_LOAD : S_LAUNCH;
      S_LOAD:   if (in_valid && load_rem == LEN_ONE) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_RUN;
      S_RUN:    if (run_done || run_tmo) state_nx = (unload_rem != '0) ? S_UNLOAD : S_DONE;
      S_UNLOAD: if (out_ready && unload_rem == LEN_ONE) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdat  = '0;
    cpu_req   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    finished  = 1'b0;
    busy      = (state != S_IDLE);
    busy_run  = (state == S_LAUNCH) || (state == S_RUN);
    case (state)
      S_LOAD: begin
        in_ready  = 1'b1;
        mem_wr_en = in_valid;
        mem_addr  = load_ptr;
        mem_wdat  = in_data;
      end
      S_LAUNCH: cpu_req = 1'b1;
      S_UNLOAD: begin
        out_valid = 1'b1;
        mem_addr  = unload_ptr;
        out_data  = mem_rdat;
      end
      S_DONE:   finished = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_ptr   <= '0;
      unload_ptr <= '0;
      load_rem   <= '0;
      unload_rem <= '0;
      cycles     <= '0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          load_ptr   <= load_base;
          load_rem   <= load_len;
          unload_ptr <= unload_base;
          unload_rem <= unload_len;
          cycles     <= '0;
          timed_out  <= 1'b0;
        end
        S_LOAD: if (in_valid) begin
          load_ptr <= load_ptr + 1'b1;
          load_rem <= load_rem - LEN_ONE;
        end
        S_RUN: begin
          if (cycles != CYC_MAX) cycles <= cycles + 1'b1;
          if (run_tmo && !run_done) timed_out <= 1'b1;
        end
        S_UNLOAD: if (out_ready) begin
          unload_ptr <= unload_ptr + 1'b1;
          unload_rem <= unload_rem - LEN_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef RUN_CTRL_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              sum_q <= '0;
    else if (state == S_IDLE && start)      sum_q <= '0;
    else if (state == S_UNLOAD && out_ready) sum_q <= sum_q + mem_rdat;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
